// File: rtl/buff16_seq_ctrl_if.sv
// Filter-buffer sequencer bus: run control in, memory read request and filter-buffer control out.
interface buff16_seq_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int PASS_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [PASS_W-1:0] num_passes;
    logic              out_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              buf_clr;
    logic              buf_write_en;
    logic [5:0]        buf_row;
    logic              buf_read_en;
    logic              data_valid;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_idx;

    modport master (
        output start, base_addr, num_passes, out_ready,
        input  mem_rd_en, mem_addr, buf_clr, buf_write_en, buf_row,
               buf_read_en, data_valid, busy, done, pass_idx
    );

    modport slave (
        input  start, base_addr, num_passes, out_ready,
        output mem_rd_en, mem_addr, buf_clr, buf_write_en, buf_row,
               buf_read_en, data_valid, busy, done, pass_idx
    );
endinterface

// File: rtl/buff16_seq_ctrl.sv
// Loads four 32-bit filter rows from main memory, then streams the 16 filter bytes num_passes times.
// First read strobe 5+MEM_LAT cycles after start; out_ready low stalls byte issue only, never the pipeline.
module buff16_seq_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int PASS_W  = 8
) (
    input logic             clk,
    input logic             rst,
    buff16_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_STREAM, S_FLUSH, S_DONE
    } state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] base_q;
    logic [PASS_W-1:0] np_q;
    logic [PASS_W-1:0] pass_q;
    logic [1:0]        ld_cnt;
    logic [3:0]        byte_cnt;
    logic              dv_q;
    logic              vld_pipe [MEM_LAT];
    logic [1:0]        row_pipe [MEM_LAT];

    logic wr_vld;
    logic [1:0] wr_row;
    logic rd_en;
    logic last_strobe;

    assign wr_vld      = vld_pipe[MEM_LAT-1];
    assign wr_row      = row_pipe[MEM_LAT-1];
    assign rd_en       = (state == S_STREAM) && bus.out_ready;
    assign last_strobe = rd_en && (byte_cnt == 4'hF) && (pass_q == np_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (bus.start) nxt = S_LOAD;
            S_LOAD:   if (ld_cnt == 2'd3) nxt = S_DRAIN;
            // Streaming only begins once the row-3 write has landed, so reads never overlap writes
            S_DRAIN:  if (wr_vld && wr_row == 2'd3) nxt = (np_q == '0) ? S_FLUSH : S_STREAM;
            S_STREAM: if (last_strobe) nxt = S_FLUSH;
            S_FLUSH:  nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd_en    = (state == S_LOAD);
        bus.mem_addr     = (state == S_LOAD) ? base_q + ADDR_W'(ld_cnt) : '0;
        bus.buf_clr      = (state == S_LOAD) && (ld_cnt == 2'd0);
        bus.buf_write_en = wr_vld;
        bus.buf_row      = wr_vld ? {4'b0000, wr_row} : 6'd0;
        bus.buf_read_en  = rd_en;
        bus.data_valid   = dv_q;
        bus.busy         = (state != S_IDLE);
        bus.done         = (state == S_DONE);
        bus.pass_idx     = pass_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            np_q     <= '0;
            pass_q   <= '0;
            ld_cnt   <= '0;
            byte_cnt <= '0;
            dv_q     <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                row_pipe[i] <= 2'd0;
            end
        end else begin
            dv_q        <= rd_en;
            vld_pipe[0] <= (state == S_LOAD);
            row_pipe[0] <= ld_cnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
            case (state)
                S_IDLE: if (bus.start) begin
                    base_q   <= bus.base_addr;
                    np_q     <= bus.num_passes;
                    pass_q   <= '0;
                    ld_cnt   <= '0;
                    byte_cnt <= '0;
                end
                S_LOAD: ld_cnt <= ld_cnt + 2'd1;
                S_STREAM: if (rd_en) begin
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'hF) pass_q <= pass_q + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_buff16_seq_ctrl.sv
// Directed bench: models main memory and the filter buffer around the sequencer, checks timing and byte order.
module tb_buff16_seq_ctrl;
    localparam int MEM_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    buff16_seq_ctrl_if #(.ADDR_W(8), .PASS_W(8)) bus ();

    buff16_seq_ctrl #(.ADDR_W(8), .MEM_LAT(MEM_LAT), .PASS_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int tcyc = 0;
    int t0 = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    bit ready_mode = 1'b0;
    bit [3:0] pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_mode ? pat[tcyc % 4] : 1'b1;
    end

    logic [31:0] mem [0:255];
    logic [31:0] fb [0:3];
    logic [3:0]  fb_idx;
    logic [31:0] memq [$];
    logic [7:0]  rdq [$];
    logic [7:0]  addr_log [0:7];
    int n_rd, first_rd_c, n_clr, clr_c, n_wr, first_wr_c, row_err, overlap;
    int n_re, first_re_c, last_re_c, re_low, pass_err, stalls, exp_total;
    int n_dv, first_dv_c, byte_err, dv_err, n_done, done_c, n_busy;
    bit prev_re;

    always @(negedge clk) begin : mon
        int c;
        logic [7:0] b;
        c = tcyc - t0;
        if (bus.data_valid !== prev_re) dv_err++;
        if (bus.data_valid) begin
            if (n_dv == 0) first_dv_c = c;
            if (rdq.size() == 0) dv_err++;
            else begin
                b = rdq.pop_front();
                if (b !== 8'(n_dv % 16)) byte_err++;
            end
            n_dv++;
        end
        if (bus.buf_clr) begin n_clr++; clr_c = c; fb_idx = 4'd0; end
        if (bus.buf_write_en) begin
            if (n_wr == 0) first_wr_c = c;
            if (bus.buf_row !== 6'(n_wr % 4)) row_err++;
            if (memq.size() == 0) row_err++;
            else fb[bus.buf_row[1:0]] = memq.pop_front();
            n_wr++;
        end
        if (bus.mem_rd_en) begin
            if (n_rd < 8) addr_log[n_rd] = bus.mem_addr;
            if (n_rd == 0) first_rd_c = c;
            memq.push_back(mem[bus.mem_addr]);
            n_rd++;
        end
        if (!bus.out_ready && bus.busy && c >= 5 + MEM_LAT && n_re < exp_total) stalls++;
        if (bus.buf_read_en) begin
            if (!bus.out_ready) re_low++;
            if (bus.buf_write_en) overlap++;
            if (bus.pass_idx !== 8'(n_re / 16)) pass_err++;
            if (n_re == 0) first_re_c = c;
            last_re_c = c;
            rdq.push_back(fb[fb_idx[3:2]][{fb_idx[1:0], 3'b000} +: 8]);
            fb_idx = fb_idx + 4'd1;
            n_re++;
        end
        if (bus.done) begin n_done++; done_c = c; end
        if (bus.busy) n_busy++;
        prev_re = bus.buf_read_en;
    end

    task automatic clear_mon();
        n_rd = 0; first_rd_c = -1; n_clr = 0; clr_c = -1; n_wr = 0; first_wr_c = -1;
        row_err = 0; overlap = 0; n_re = 0; first_re_c = -1; last_re_c = -1; re_low = 0;
        pass_err = 0; stalls = 0; n_dv = 0; first_dv_c = -1; byte_err = 0; dv_err = 0;
        n_done = 0; done_c = -1; n_busy = 0;
        memq.delete(); rdq.delete();
    endtask

    task automatic run(input logic [7:0] base, input logic [7:0] np, input bit hold);
        for (int r = 0; r < 4; r++) begin
            logic [7:0] a;
            a = base + 8'(r);
            mem[a] = {8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)};
        end
        @(negedge clk);
        clear_mon();
        exp_total = 16 * int'(np);
        bus.start = 1'b1; bus.base_addr = base; bus.num_passes = np;
        @(posedge clk); #1;
        t0 = tcyc - 1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1'b1; break; end
        end
        bus.start = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.num_passes = '0;
        prev_re = 1'b0; fb_idx = 4'd0;
        for (int a = 0; a < 256; a++) mem[a] = 32'hDEAD_BEEF;
        for (int r = 0; r < 4; r++) fb[r] = 32'h0;
        clear_mon();
        exp_total = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {bus.mem_rd_en, bus.buf_clr, bus.buf_write_en, bus.buf_read_en,
                        bus.data_valid, bus.busy, bus.done}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_row_pass", {bus.buf_row, bus.pass_idx}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // basic single pass
        run(8'h10, 8'd1, 1'b0); wait_done();
        chk("t1_first_rd", first_rd_c, 1);
        chk("t1_n_rd", n_rd, 4);
        chk("t1_addr0", addr_log[0], 8'h10);
        chk("t1_addr3", addr_log[3], 8'h13);
        chk("t1_clr", {n_clr[7:0], clr_c[7:0]}, {8'd1, 8'd1});
        chk("t1_first_wr", first_wr_c, 2);
        chk("t1_wr", {n_wr[7:0], row_err[7:0]}, {8'd4, 8'd0});
        chk("t1_first_re", first_re_c, 6);
        chk("t1_last_re", last_re_c, 21);
        chk("t1_first_dv", first_dv_c, 7);
        chk("t1_bytes", {n_dv[7:0], byte_err[7:0], dv_err[7:0]}, {8'd16, 8'd0, 8'd0});
        chk("t1_done", {n_done[7:0], done_c[7:0]}, {8'd1, 8'd23});
        chk("t1_busy", n_busy, 23);
        chk("t1_overlap", overlap, 0);

        // three passes
        run(8'h20, 8'd3, 1'b0); wait_done();
        chk("t2_n_re", n_re, 48);
        chk("t2_bytes", {n_dv[7:0], byte_err[7:0], dv_err[7:0]}, {8'd48, 8'd0, 8'd0});
        chk("t2_pass", pass_err, 0);
        chk("t2_done", {n_done[7:0], done_c[7:0]}, {8'd1, 8'd55});

        // backpressure 1,0,0,1
        ready_mode = 1'b1;
        run(8'h30, 8'd1, 1'b0); wait_done();
        ready_mode = 1'b0;
        chk("t3_re_low", re_low, 0);
        chk("t3_stalled", 32'(stalls > 0), 32'd1);
        chk("t3_bytes", {n_dv[7:0], byte_err[7:0], dv_err[7:0]}, {8'd16, 8'd0, 8'd0});
        chk("t3_done", done_c, 23 + stalls);

        // address wrap
        run(8'hFE, 8'd1, 1'b0); wait_done();
        chk("t4_addr", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, 32'hFEFF_0001);
        chk("t4_bytes", byte_err, 0);

        // start held high for the whole run
        run(8'h40, 8'd2, 1'b1); wait_done();
        chk("t5_done", n_done, 1);
        chk("t5_n_rd", n_rd, 4);
        chk("t5_n_re", n_re, 32);
        chk("t5_idle", bus.busy, 1'b0);

        // reset mid-stream, then restart
        run(8'h50, 8'd2, 1'b0);
        for (int i = 0; i < 200 && n_re < 10; i++) @(negedge clk);
        rst = 1'b0; #1;
        chk("t6_rst_outs", {bus.mem_rd_en, bus.buf_write_en, bus.buf_read_en,
                            bus.data_valid, bus.busy, bus.done}, 32'd0);
        chk("t6_rst_pass", bus.pass_idx, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", n_done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run(8'h50, 8'd1, 1'b0); wait_done();
        chk("t6_restart_clr", clr_c, 1);
        chk("t6_restart_bytes", {n_dv[7:0], byte_err[7:0]}, {8'd16, 8'd0});
        chk("t6_restart_done", done_c, 23);

        // zero passes
        run(8'h60, 8'd0, 1'b0); wait_done();
        chk("t7_n_re", n_re, 0);
        chk("t7_done", {n_done[7:0], done_c[7:0]}, {8'd1, 8'(7 + MEM_LAT - 1)});
        chk("t7_n_wr", n_wr, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/buff16_seq_ctrl.md
Name: buff16_seq_ctrl

Overview:
Sequencer for the 16-byte (4x4) filter buffer in the CNN datapath. On start it fetches four 32-bit rows from main buffer memory and writes them into the filter buffer as rows 0..3. It then streams the 16 bytes out num_passes times, once per convolution window. Stream issue is gated by a downstream ready signal.

Parameters:
ADDR_W, 8, main-memory word address width
MEM_LAT, 1, cycles from mem_rd_en to data valid on the main-memory read bus (>=1)
PASS_W, 8, width of num_passes and pass_idx

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin load+stream; sampled only in IDLE
base_addr  in  ADDR_W  address of filter row 0; rows at base_addr+0..3, modulo 2^ADDR_W
num_passes  in  PASS_W  number of 16-byte streams; captured with start
out_ready  in  1  downstream can accept a byte issued this cycle
mem_rd_en  out  1  main-memory read request
mem_addr  out  ADDR_W  main-memory read address
buf_clr  out  1  active-high clear pulse to filter buffer (zeroes its read index and output)
buf_write_en  out  1  filter-buffer row write, aligned with memory read data
buf_row  out  6  filter-buffer row address (0..3)
buf_read_en  out  1  filter-buffer byte read strobe
data_valid  out  1  filter-buffer output byte valid this cycle
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
pass_idx  out  PASS_W  index of the pass currently streaming

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; counters and delay pipeline cleared. Filter-buffer contents are not touched.
- Reset mid-operation aborts at once. No done pulse. The next start performs a full reload.
- States: IDLE, LOAD, DRAIN, STREAM, FLUSH, DONE.
- IDLE: start=1 at an edge captures base_addr and num_passes and moves to LOAD. start is ignored in every other state.
- LOAD, 4 cycles: mem_rd_en=1, mem_addr=base_addr+k for k=0..3. buf_clr=1 only in the first LOAD cycle.
- Write pipeline: each read request travels a MEM_LAT-deep valid+row delay line. buf_write_en=1 and buf_row=k exactly MEM_LAT cycles after request k.
- DRAIN: wait until the row-3 write has been asserted, then go to STREAM on the next cycle. A read never occurs in the same cycle as a write.
- STREAM: buf_read_en = out_ready.
  - Each strobe increments a 4-bit byte counter; the counter wraps 15->0.
  - On wrap, pass_idx increments.
  - After 16*num_passes strobes, go to FLUSH.
  - out_ready low stalls issue only.
- data_valid = buf_read_en delayed by exactly 1 cycle, independent of out_ready. The consumer must take every byte it enabled.
- FLUSH: 1 cycle, carries the final data_valid. Then DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- num_passes=0: LOAD/DRAIN still run, STREAM is skipped (no buf_read_en), FLUSH->DONE follow.
- The read count per run is always a multiple of 16, so the buffer index ends at 0. buf_clr additionally guarantees index 0 at each run start.
- Timeline, MEM_LAT=1, out_ready=1, start sampled at edge of cycle 0:
  - LOAD cycles 1-4 (buf_clr cycle 1).
  - writes cycles 2-5.
  - reads cycles 6-21, data_valid 7-22.
  - FLUSH 22, done 23, busy 1-23.
  - General first read cycle: 5+MEM_LAT.

Test Plan:
1. MEM_LAT=1, base_addr=8'h10, num_passes=1, out_ready=1, memory rows 0x03020100..0x0F0E0D0C -> mem_addr 0x10-0x13 in cycles 1-4; buf_row 0-3 in cycles 2-5; bytes 0x00..0x0F on data_valid cycles 7-22; done at 23.
2. num_passes=3 -> 48 buf_read_en strobes; byte sequence 0x00..0x0F repeated 3 times; pass_idx 0,1,2; a single done pulse.
3. out_ready toggled 1,0,0,1 pattern during STREAM -> no buf_read_en while low; byte order unbroken; done delayed by the stall count.
4. base_addr=8'hFE -> mem_addr FE, FF, 00, 01 (wrap).
5. start held high through the run, plus a second start pulse mid-STREAM -> ignored; exactly one done; a new run begins only from IDLE.
6. rst=0 asserted in STREAM cycle 10, released, then restarted -> outputs 0 immediately; no done; restarted run begins with buf_clr and streams from byte 0x00. Also num_passes=0 -> no buf_read_en, done at cycle 7+MEM_LAT-1.
